// File: rtl/cm0ik_misc_delay_chk_pkg.sv
// Shared definitions for the misc-logic delay-element loopback checker:
// FSM state encoding and default latency/timeout constants.
package cm0ik_misc_delay_chk_pkg;

  localparam int DEF_EXP_DELAY = 4;
  localparam int DEF_TIMEOUT   = 15;
  localparam int DEF_CNT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_TAIL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/cm0ik_misc_delay_chk.sv
// Loopback initiator/checker: launches a one-cycle pulse into the delay element,
// measures the round-trip latency and returned width, and reports pass/fail.
module cm0ik_misc_delay_chk
  import cm0ik_misc_delay_chk_pkg::*;
#(
  parameter int EXP_DELAY = DEF_EXP_DELAY,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             fclk,
  input  logic             hreset,
  input  logic             start,
  output logic             dly_i,
  input  logic             dly_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] measured,
  output logic             err_stuck,
  output logic             err_timeout,
  output logic             err_width
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_DELAY);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             dly_i_q, dly_i_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             err_stuck_q, err_stuck_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_width_q, err_width_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q;
    meas_d        = meas_q;
    pass_d        = pass_q;
    err_stuck_d   = err_stuck_q;
    err_timeout_d = err_timeout_q;
    err_width_d   = err_width_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pass_d        = 1'b0;
          meas_d        = '0;
          err_stuck_d   = 1'b0;
          err_timeout_d = 1'b0;
          err_width_d   = 1'b0;
          cnt_d         = '0;
          if (dly_o) begin
            err_stuck_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (dly_o) begin
          meas_d  = '0;
          state_d = ST_TAIL;
        end else begin
          cnt_d   = ONE_C;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A return seen in the timeout cycle still counts as a valid return.
        if (dly_o) begin
          meas_d  = cnt_q;
          state_d = ST_TAIL;
        end else if (cnt_q == TIMEOUT_C) begin
          meas_d        = TIMEOUT_C;
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_TAIL: begin
        if (dly_o) err_width_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are computed from the state being entered.
    if (state_d == ST_DONE) begin
      pass_d = (meas_d == EXP_C) && !err_stuck_d && !err_timeout_d && !err_width_d;
    end
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    dly_i_d = (state_d == ST_DRIVE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge fclk or posedge hreset) begin
    if (hreset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      meas_q        <= '0;
      dly_i_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_stuck_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_width_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      meas_q        <= meas_d;
      dly_i_q       <= dly_i_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_stuck_q   <= err_stuck_d;
      err_timeout_q <= err_timeout_d;
      err_width_q   <= err_width_d;
    end
  end

  assign dly_i       = dly_i_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign measured    = meas_q;
  assign err_stuck   = err_stuck_q;
  assign err_timeout = err_timeout_q;
  assign err_width   = err_width_q;

endmodule

// File: tb/tb_cm0ik_misc_delay_chk.sv
// Self-checking bench for cm0ik_misc_delay_chk with a configurable delay-element model
// between dly_i and dly_o (latency, returned width, tie-low, stuck-high).
module tb_cm0ik_misc_delay_chk;
  import cm0ik_misc_delay_chk_pkg::*;

  localparam int EXP = DEF_EXP_DELAY;
  localparam int TMO = DEF_TIMEOUT;
  localparam int CW  = DEF_CNT_W;

  logic          fclk = 1'b0;
  logic          hreset;
  logic          start;
  logic          dly_i;
  logic          dly_o;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] measured;
  logic          err_stuck;
  logic          err_timeout;
  logic          err_width;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 fclk = ~fclk;

  cm0ik_misc_delay_chk #(
    .EXP_DELAY(EXP),
    .TIMEOUT  (TMO),
    .CNT_W    (CW)
  ) u_dut (
    .fclk       (fclk),
    .hreset     (hreset),
    .start      (start),
    .dly_i      (dly_i),
    .dly_o      (dly_o),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .measured   (measured),
    .err_stuck  (err_stuck),
    .err_timeout(err_timeout),
    .err_width  (err_width)
  );

  // Delay element: a pulse on dly_i in T0 appears on dly_o in T(dly_n).
  logic [31:0] sr;
  int          dly_n       = 4;
  int          dly_w       = 1;
  bit          tie0        = 1'b0;
  bit          stuck_force = 1'b0;

  always_ff @(posedge fclk or posedge hreset) begin
    if (hreset) sr <= '0;
    else        sr <= {sr[30:0], dly_i};
  end

  always_comb begin
    dly_o = 1'b0;
    if (tie0)             dly_o = 1'b0;
    else if (stuck_force) dly_o = 1'b1;
    else begin
      dly_o = sr[dly_n-1];
      if (dly_w > 1) dly_o = dly_o | sr[dly_n];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: outcome of one check from the delay-element behaviour alone.
  function automatic void model(input int d, input int w, input bit stk, input bit t0,
                                output int meas, output bit p, output bit st,
                                output bit to, output bit wd, output int dt);
    st = stk; to = 1'b0; wd = 1'b0;
    if (stk) begin
      meas = 0; dt = 0;
    end else if (t0 || d > TMO) begin
      meas = TMO; to = 1'b1; dt = TMO + 1;
    end else begin
      meas = d; wd = (w > 1); dt = d + 2;
    end
    p = !st && !to && !wd && (meas == EXP);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run(input string tag, input int d, input int w, input bit stk,
                     input bit t0, input bit hold, input int e_meas, input bit e_pass,
                     input bit e_st, input bit e_to, input bit e_wd, input int e_done);
    int          n;
    int          done_t;
    int          done_cnt;
    int          dlyi_cnt;
    int          dlyi_t;
    logic        busy_t0;
    logic [31:0] mask;
    mask = (32'd1 << (d + 1)) - 32'd1;
    n = 0;
    while (((sr & mask) != 0) && n < 64) begin
      @(negedge fclk);
      n++;
    end
    dly_n = d; dly_w = w; tie0 = t0; stuck_force = stk;
    start = 1'b1;
    @(posedge fclk);
    #1;
    stuck_force = 1'b0;
    if (!hold) start = 1'b0;
    done_t = -1; done_cnt = 0; dlyi_cnt = 0; dlyi_t = -1; busy_t0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge fclk);
      if (k == 0) busy_t0 = busy;
      if (dly_i === 1'b1) begin
        dlyi_cnt++;
        if (dlyi_t < 0) dlyi_t = k;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_t < 0) begin
          done_t = k;
          start  = 1'b0;
          check({tag, " measured"},    32'(measured),    32'(e_meas));
          check({tag, " pass"},        32'(pass),        32'(e_pass));
          check({tag, " err_stuck"},   32'(err_stuck),   32'(e_st));
          check({tag, " err_timeout"}, 32'(err_timeout), 32'(e_to));
          check({tag, " err_width"},   32'(err_width),   32'(e_wd));
        end
      end
      if (done_t >= 0 && k == done_t + 1) begin
        check({tag, " busy after done"}, 32'(busy), 32'd0);
        check({tag, " pass held"},       32'(pass), 32'(e_pass));
        break;
      end
    end
    start = 1'b0;
    check({tag, " done cycle"},   32'(done_t),   32'(e_done));
    check({tag, " done count"},   32'(done_cnt), 32'd1);
    check({tag, " busy in T0"},   32'(busy_t0),  32'd1);
    check({tag, " dly_i pulses"}, 32'(dlyi_cnt), stk ? 32'd0 : 32'd1);
    check({tag, " dly_i cycle"},  32'(dlyi_t),   stk ? 32'hFFFF_FFFF : 32'd0);
  endtask

  typedef struct {
    int d;
    int w;
    bit stk;
    bit t0;
    bit hold;
    int meas;
    bit p;
    bit st;
    bit to;
    bit wd;
    int dt;
  } vec_t;

  vec_t vecs[9];

  task automatic check_all_zero(input string tag);
    check({tag, " dly_i"},       32'(dly_i),       32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " done"},        32'(done),        32'd0);
    check({tag, " pass"},        32'(pass),        32'd0);
    check({tag, " measured"},    32'(measured),    32'd0);
    check({tag, " err_stuck"},   32'(err_stuck),   32'd0);
    check({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, " err_width"},   32'(err_width),   32'd0);
  endtask

  initial begin
    int   rd, rw, rmeas, rdt, ndone;
    bit   rstk, rhold, rp, rst_e, rto, rwd;
    //          d   w  stk t0 hold meas p  st to wd done_t
    vecs[0] = '{4,  1, 0,  0, 0,   4,   1, 0, 0, 0, 6};   // nominal
    vecs[1] = '{3,  1, 0,  0, 0,   3,   0, 0, 0, 0, 5};   // short, back-to-back
    vecs[2] = '{5,  1, 0,  0, 0,   5,   0, 0, 0, 0, 7};   // long
    vecs[3] = '{16, 1, 0,  1, 0,   15,  0, 0, 1, 0, 16};  // no return
    vecs[4] = '{4,  1, 1,  0, 0,   0,   0, 1, 0, 0, 0};   // stuck high at start
    vecs[5] = '{4,  2, 0,  0, 0,   4,   0, 0, 0, 1, 6};   // 2-cycle return
    vecs[6] = '{4,  1, 0,  0, 1,   4,   1, 0, 0, 0, 6};   // start held while busy
    vecs[7] = '{1,  1, 0,  0, 0,   1,   0, 0, 0, 0, 3};   // first WAIT cycle
    vecs[8] = '{15, 1, 0,  0, 0,   15,  0, 0, 0, 0, 17};  // return in timeout cycle

    hreset = 1'b1;
    start  = 1'b0;
    repeat (3) @(negedge fclk);
    check_all_zero("reset");
    hreset = 1'b0;
    @(negedge fclk);

    foreach (vecs[i]) begin
      run($sformatf("vec%0d", i), vecs[i].d, vecs[i].w, vecs[i].stk, vecs[i].t0,
          vecs[i].hold, vecs[i].meas, vecs[i].p, vecs[i].st, vecs[i].to,
          vecs[i].wd, vecs[i].dt);
    end

    // Reset in T2 of WAIT aborts the check with no done pulse.
    run("pre-abort", 4, 1, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    dly_n = 4; dly_w = 1; tie0 = 1'b0;
    start = 1'b1;
    @(posedge fclk);
    #1 start = 1'b0;
    repeat (3) @(negedge fclk);
    hreset = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge fclk);
    hreset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge fclk);
      if (done === 1'b1) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    run("post-abort", 4, 1, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 6);

    for (int i = 0; i < 40; i++) begin
      rstk  = ($urandom_range(0, 9) == 0);
      rd    = int'($urandom_range(1, 17));
      rw    = int'($urandom_range(1, 2));
      rhold = 1'($urandom_range(0, 1));
      model(rd, rw, rstk, 1'b0, rmeas, rp, rst_e, rto, rwd, rdt);
      run($sformatf("rnd%0d d=%0d w=%0d s=%0d", i, rd, rw, rstk), rd, rw, rstk, 1'b0,
          rhold, rmeas, rp, rst_e, rto, rwd, rdt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
